// File: rtl/reorder_buffer.sv
// Circular in-order commit buffer: allocates tags at dispatch, collects CDB results,
// answers operand queries and retires in program order with store release and flush.
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int ROB_W    = 4,
    parameter int DATA_W   = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              ROB_S,
    input  logic [4:0]        Dispatch_rd,
    input  logic              Dispatch_rd_we,
    input  logic              Dispatch_is_store,
    input  logic [DATA_W-1:0] Dispatch_pc,
    output logic [ROB_W-1:0]  ROB_nxtpos,
    output logic              ROB_full,
    input  logic              ROB_rs1_S,
    input  logic [ROB_W-1:0]  ROB_rs1_Reorder,
    output logic              ROB_rs1_already,
    output logic [DATA_W-1:0] ROB_rs1_value,
    input  logic              ROB_rs2_S,
    input  logic [ROB_W-1:0]  ROB_rs2_Reorder,
    output logic              ROB_rs2_already,
    output logic [DATA_W-1:0] ROB_rs2_value,
    input  logic              ALU_S,
    input  logic [ROB_W-1:0]  ALU_Reorder,
    input  logic [DATA_W-1:0] ALU_value,
    input  logic              ALU_mispred,
    input  logic [DATA_W-1:0] ALU_newpc,
    input  logic              LSB_S,
    input  logic [ROB_W-1:0]  LSB_Reorder,
    input  logic [DATA_W-1:0] LSB_value,
    output logic              Commit_S,
    output logic [4:0]        Commit_rd,
    output logic [DATA_W-1:0] Commit_value,
    output logic [ROB_W-1:0]  Commit_Reorder,
    output logic              Store_commit_S,
    output logic [ROB_W-1:0]  Store_commit_Reorder,
    output logic              Flush_S,
    output logic [DATA_W-1:0] Flush_pc
);

    localparam logic [ROB_W:0] FULL_COUNT = (ROB_W+1)'(ROB_SIZE);

    logic [ROB_W-1:0]  head, tail;
    logic [ROB_W:0]    count;
    logic [ROB_SIZE-1:0] valid_q, ready_q;

    logic [ROB_SIZE-1:0] rd_we_q, is_store_q, mispred_q;
    logic [4:0]          rd_q    [ROB_SIZE];
    logic [DATA_W-1:0]   pc_q    [ROB_SIZE];
    logic [DATA_W-1:0]   value_q [ROB_SIZE];
    logic [DATA_W-1:0]   newpc_q [ROB_SIZE];

    logic commit_fire, flush_fire, alloc_fire, alu_wb, lsb_wb;
    logic unused_entry_pc;

    assign ROB_nxtpos = tail;
    assign ROB_full   = (count == FULL_COUNT);

    assign commit_fire = rdy_in && (count != '0) && ready_q[head];
    assign flush_fire  = commit_fire && mispred_q[head];
    assign alloc_fire  = rdy_in && ROB_S && !ROB_full && !flush_fire;
    assign alu_wb      = rdy_in && ALU_S && valid_q[ALU_Reorder] && !flush_fire;
    assign lsb_wb      = rdy_in && LSB_S && valid_q[LSB_Reorder] && !flush_fire;

    // The pc is kept per entry for debug visibility; no retire path consumes it yet.
    assign unused_entry_pc = ^pc_q[head];

    // Results still on the CDB this cycle take priority over stored entry values.
    function automatic logic [DATA_W:0] lookup(input logic en, input logic [ROB_W-1:0] tag);
        logic [DATA_W:0] result;
        result = '0;
        if (en) begin
            if (ALU_S && ALU_Reorder == tag)
                result = {1'b1, ALU_value};
            else if (LSB_S && LSB_Reorder == tag)
                result = {1'b1, LSB_value};
            else if (ready_q[tag])
                result = {1'b1, value_q[tag]};
        end
        return result;
    endfunction

    assign {ROB_rs1_already, ROB_rs1_value} = lookup(ROB_rs1_S, ROB_rs1_Reorder);
    assign {ROB_rs2_already, ROB_rs2_value} = lookup(ROB_rs2_S, ROB_rs2_Reorder);

    always_ff @(posedge clk_in) begin
        if (alloc_fire) begin
            rd_q[tail]       <= Dispatch_rd;
            rd_we_q[tail]    <= Dispatch_rd_we;
            is_store_q[tail] <= Dispatch_is_store;
            pc_q[tail]       <= Dispatch_pc;
        end
        if (alu_wb) begin
            value_q[ALU_Reorder]   <= ALU_value;
            mispred_q[ALU_Reorder] <= ALU_mispred;
            newpc_q[ALU_Reorder]   <= ALU_newpc;
        end
        if (lsb_wb) begin
            value_q[LSB_Reorder]   <= LSB_value;
            mispred_q[LSB_Reorder] <= 1'b0;
        end
    end

    // Flush is applied last so it overrides the commit and allocation of the same edge.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head                 <= '0;
            tail                 <= '0;
            count                <= '0;
            valid_q              <= '0;
            ready_q              <= '0;
            Commit_S             <= 1'b0;
            Commit_rd            <= '0;
            Commit_value         <= '0;
            Commit_Reorder       <= '0;
            Store_commit_S       <= 1'b0;
            Store_commit_Reorder <= '0;
            Flush_S              <= 1'b0;
            Flush_pc             <= '0;
        end else begin
            Commit_S       <= 1'b0;
            Store_commit_S <= 1'b0;
            Flush_S        <= 1'b0;
            if (alu_wb)
                ready_q[ALU_Reorder] <= 1'b1;
            if (lsb_wb)
                ready_q[LSB_Reorder] <= 1'b1;
            if (commit_fire) begin
                valid_q[head]        <= 1'b0;
                ready_q[head]        <= 1'b0;
                head                 <= head + ROB_W'(1);
                Commit_S             <= rd_we_q[head];
                Commit_rd            <= rd_q[head];
                Commit_value         <= value_q[head];
                Commit_Reorder       <= head;
                Store_commit_S       <= is_store_q[head];
                Store_commit_Reorder <= head;
                Flush_S              <= mispred_q[head];
                Flush_pc             <= newpc_q[head];
            end
            if (alloc_fire) begin
                valid_q[tail] <= 1'b1;
                ready_q[tail] <= 1'b0;
                tail          <= tail + ROB_W'(1);
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count <= count + (ROB_W+1)'(1);
                2'b01:   count <= count - (ROB_W+1)'(1);
                default: ;
            endcase
            if (flush_fire) begin
                valid_q <= '0;
                ready_q <= '0;
                head    <= '0;
                tail    <= '0;
                count   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a queue-based program-order model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_reorder_buffer;

    localparam int ROB_SIZE = 16;
    localparam int ROB_W    = 4;
    localparam int DATA_W   = 32;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b0;
    logic              rdy_in = 1'b1;
    logic              ROB_S = 1'b0;
    logic [4:0]        Dispatch_rd = '0;
    logic              Dispatch_rd_we = 1'b0;
    logic              Dispatch_is_store = 1'b0;
    logic [DATA_W-1:0] Dispatch_pc = '0;
    logic [ROB_W-1:0]  ROB_nxtpos;
    logic              ROB_full;
    logic              ROB_rs1_S = 1'b0;
    logic [ROB_W-1:0]  ROB_rs1_Reorder = '0;
    logic              ROB_rs1_already;
    logic [DATA_W-1:0] ROB_rs1_value;
    logic              ROB_rs2_S = 1'b0;
    logic [ROB_W-1:0]  ROB_rs2_Reorder = '0;
    logic              ROB_rs2_already;
    logic [DATA_W-1:0] ROB_rs2_value;
    logic              ALU_S = 1'b0;
    logic [ROB_W-1:0]  ALU_Reorder = '0;
    logic [DATA_W-1:0] ALU_value = '0;
    logic              ALU_mispred = 1'b0;
    logic [DATA_W-1:0] ALU_newpc = '0;
    logic              LSB_S = 1'b0;
    logic [ROB_W-1:0]  LSB_Reorder = '0;
    logic [DATA_W-1:0] LSB_value = '0;
    logic              Commit_S;
    logic [4:0]        Commit_rd;
    logic [DATA_W-1:0] Commit_value;
    logic [ROB_W-1:0]  Commit_Reorder;
    logic              Store_commit_S;
    logic [ROB_W-1:0]  Store_commit_Reorder;
    logic              Flush_S;
    logic [DATA_W-1:0] Flush_pc;

    int pass_count  = 0;
    int check_count = 0;

    always #5 clk_in = ~clk_in;

    reorder_buffer #(.ROB_SIZE(ROB_SIZE), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .ROB_S(ROB_S), .Dispatch_rd(Dispatch_rd), .Dispatch_rd_we(Dispatch_rd_we),
        .Dispatch_is_store(Dispatch_is_store), .Dispatch_pc(Dispatch_pc),
        .ROB_nxtpos(ROB_nxtpos), .ROB_full(ROB_full),
        .ROB_rs1_S(ROB_rs1_S), .ROB_rs1_Reorder(ROB_rs1_Reorder),
        .ROB_rs1_already(ROB_rs1_already), .ROB_rs1_value(ROB_rs1_value),
        .ROB_rs2_S(ROB_rs2_S), .ROB_rs2_Reorder(ROB_rs2_Reorder),
        .ROB_rs2_already(ROB_rs2_already), .ROB_rs2_value(ROB_rs2_value),
        .ALU_S(ALU_S), .ALU_Reorder(ALU_Reorder), .ALU_value(ALU_value),
        .ALU_mispred(ALU_mispred), .ALU_newpc(ALU_newpc),
        .LSB_S(LSB_S), .LSB_Reorder(LSB_Reorder), .LSB_value(LSB_value),
        .Commit_S(Commit_S), .Commit_rd(Commit_rd), .Commit_value(Commit_value),
        .Commit_Reorder(Commit_Reorder),
        .Store_commit_S(Store_commit_S), .Store_commit_Reorder(Store_commit_Reorder),
        .Flush_S(Flush_S), .Flush_pc(Flush_pc)
    );

    typedef struct {
        int          tag;
        logic [4:0]  rd;
        logic        rd_we;
        logic        is_store;
        logic        ready;
        logic [31:0] value;
        logic        mis;
        logic [31:0] newpc;
    } entry_t;

    // Live entries in program order; front is the oldest instruction.
    entry_t rob_q[$];
    int     next_tag = 0;
    logic        exp_commit_s = 0, exp_store_s = 0, exp_flush_s = 0;
    logic [4:0]  exp_commit_rd = '0;
    logic [31:0] exp_commit_value = '0, exp_flush_pc = '0;
    int          exp_commit_tag = 0, exp_store_tag = 0;

    entry_t m_head, m_e;
    bit     m_commit, m_flush, m_was_full;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    function automatic logic [32:0] exp_query(input logic en, input logic [3:0] tag);
        if (!en) return '0;
        if (ALU_S && ALU_Reorder == tag) return {1'b1, ALU_value};
        if (LSB_S && LSB_Reorder == tag) return {1'b1, LSB_value};
        foreach (rob_q[i])
            if (rob_q[i].tag == int'(tag) && rob_q[i].ready) return {1'b1, rob_q[i].value};
        return '0;
    endfunction

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rob_q.delete();
            next_tag     = 0;
            exp_commit_s = 0;
            exp_store_s  = 0;
            exp_flush_s  = 0;
        end else begin
            exp_commit_s = 0;
            exp_store_s  = 0;
            exp_flush_s  = 0;
            if (rdy_in) begin
                m_was_full = (rob_q.size() == ROB_SIZE);
                m_commit   = (rob_q.size() > 0) && rob_q[0].ready;
                m_flush    = 0;
                if (m_commit) begin
                    m_head  = rob_q[0];
                    m_flush = m_head.mis;
                end
                if (!m_flush) begin
                    foreach (rob_q[i]) begin
                        m_e = rob_q[i];
                        if (ALU_S && m_e.tag == int'(ALU_Reorder)) begin
                            m_e.ready = 1; m_e.value = ALU_value;
                            m_e.mis = ALU_mispred; m_e.newpc = ALU_newpc;
                        end
                        if (LSB_S && m_e.tag == int'(LSB_Reorder)) begin
                            m_e.ready = 1; m_e.value = LSB_value; m_e.mis = 0;
                        end
                        rob_q[i] = m_e;
                    end
                end
                if (m_commit) begin
                    void'(rob_q.pop_front());
                    exp_commit_s     = m_head.rd_we;
                    exp_commit_rd    = m_head.rd;
                    exp_commit_value = m_head.value;
                    exp_commit_tag   = m_head.tag;
                    exp_store_s      = m_head.is_store;
                    exp_store_tag    = m_head.tag;
                    exp_flush_s      = m_head.mis;
                    exp_flush_pc     = m_head.newpc;
                end
                if (m_flush) begin
                    rob_q.delete();
                    next_tag = 0;
                end else if (ROB_S && !m_was_full) begin
                    m_e.tag = next_tag; m_e.rd = Dispatch_rd; m_e.rd_we = Dispatch_rd_we;
                    m_e.is_store = Dispatch_is_store; m_e.ready = 0; m_e.value = '0;
                    m_e.mis = 0; m_e.newpc = '0;
                    rob_q.push_back(m_e);
                    next_tag = (next_tag + 1) % ROB_SIZE;
                end
            end
        end
    end

    logic [32:0] q1, q2;
    always @(negedge clk_in) begin
        check_output("nxtpos", 32'(ROB_nxtpos), 32'(next_tag));
        check_output("full", 32'(ROB_full), 32'(rob_q.size() == ROB_SIZE));
        check_output("commit_s", 32'(Commit_S), 32'(exp_commit_s));
        if (exp_commit_s) begin
            check_output("commit_rd", 32'(Commit_rd), 32'(exp_commit_rd));
            check_output("commit_value", Commit_value, exp_commit_value);
            check_output("commit_tag", 32'(Commit_Reorder), 32'(exp_commit_tag));
        end
        check_output("store_s", 32'(Store_commit_S), 32'(exp_store_s));
        if (exp_store_s)
            check_output("store_tag", 32'(Store_commit_Reorder), 32'(exp_store_tag));
        check_output("flush_s", 32'(Flush_S), 32'(exp_flush_s));
        if (exp_flush_s)
            check_output("flush_pc", Flush_pc, exp_flush_pc);
        q1 = exp_query(ROB_rs1_S, ROB_rs1_Reorder);
        q2 = exp_query(ROB_rs2_S, ROB_rs2_Reorder);
        check_output("rs1_already", 32'(ROB_rs1_already), 32'(q1[32]));
        check_output("rs1_value", ROB_rs1_value, q1[31:0]);
        check_output("rs2_already", 32'(ROB_rs2_already), 32'(q2[32]));
        check_output("rs2_value", ROB_rs2_value, q2[31:0]);
    end

    task automatic apply_stimulus();
        @(posedge clk_in);
        #1;
        ROB_S = 0; ALU_S = 0; LSB_S = 0; ALU_mispred = 0;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic rd_we, input logic is_store);
        ROB_S = 1; Dispatch_rd = rd; Dispatch_rd_we = rd_we; Dispatch_is_store = is_store;
        Dispatch_pc = {27'd0, rd} << 2;
    endtask

    task automatic alu_write(input logic [3:0] tag, input logic [31:0] value,
                             input logic mis, input logic [31:0] newpc);
        ALU_S = 1; ALU_Reorder = tag; ALU_value = value; ALU_mispred = mis; ALU_newpc = newpc;
    endtask

    task automatic lsb_write(input logic [3:0] tag, input logic [31:0] value);
        LSB_S = 1; LSB_Reorder = tag; LSB_value = value;
    endtask

    initial begin
        repeat (2) apply_stimulus();
        rst_in = 1;
        #1;
        check_output("reset_nxtpos", 32'(ROB_nxtpos), 32'd0);
        check_output("reset_full", 32'(ROB_full), 32'd0);

        // In-order retirement despite out-of-order results.
        alloc(5, 1, 0); apply_stimulus();
        alloc(6, 1, 0); apply_stimulus();
        alloc(7, 1, 0); apply_stimulus();
        check_output("alloc3_nxtpos", 32'(ROB_nxtpos), 32'd3);
        alu_write(2, 32'h33, 0, 0); apply_stimulus();
        alu_write(0, 32'h11, 0, 0); apply_stimulus();
        alu_write(1, 32'h22, 0, 0); apply_stimulus();
        check_output("c0_s", 32'(Commit_S), 32'd1);
        check_output("c0_value", Commit_value, 32'h11);
        check_output("c0_rd", 32'(Commit_rd), 32'd5);
        apply_stimulus();
        check_output("c1_value", Commit_value, 32'h22);
        check_output("c1_tag", 32'(Commit_Reorder), 32'd1);
        apply_stimulus();
        check_output("c2_value", Commit_value, 32'h33);
        check_output("c2_tag", 32'(Commit_Reorder), 32'd2);
        apply_stimulus();
        check_output("c_idle_s", 32'(Commit_S), 32'd0);

        // Not ready: dispatch is ignored.
        rdy_in = 0; alloc(9, 1, 0); apply_stimulus();
        check_output("rdy_low_nxtpos", 32'(ROB_nxtpos), 32'd3);
        rdy_in = 1;

        // Query bypass from the CDB, then from the stored entry.
        alloc(8, 1, 0); apply_stimulus();
        ROB_rs1_S = 1; ROB_rs1_Reorder = 3; ROB_rs2_S = 1; ROB_rs2_Reorder = 3;
        #1;
        check_output("q_pending_already", 32'(ROB_rs1_already), 32'd0);
        alu_write(3, 32'hABCD, 0, 0);
        #1;
        check_output("q_bypass_already", 32'(ROB_rs1_already), 32'd1);
        check_output("q_bypass_value", ROB_rs1_value, 32'hABCD);
        apply_stimulus();
        check_output("q_stored_value", ROB_rs2_value, 32'hABCD);
        ROB_rs1_S = 0; ROB_rs2_S = 0;
        apply_stimulus();
        check_output("c3_value", Commit_value, 32'hABCD);

        // Store release.
        alloc(0, 0, 1); apply_stimulus();
        lsb_write(4, 32'hDEAD); apply_stimulus();
        apply_stimulus();
        check_output("st_s", 32'(Store_commit_S), 32'd1);
        check_output("st_tag", 32'(Store_commit_Reorder), 32'd4);
        check_output("st_commit_s", 32'(Commit_S), 32'd0);
        apply_stimulus();
        check_output("st_s_drop", 32'(Store_commit_S), 32'd0);

        // Asynchronous reset with five live entries and a pulse in flight.
        for (int i = 0; i < 6; i++) begin
            alloc(5'(10 + i), 1, 0); apply_stimulus();
        end
        alu_write(5, 32'h55, 0, 0); apply_stimulus();
        apply_stimulus();
        check_output("pre_reset_commit", 32'(Commit_S), 32'd1);
        rst_in = 0;
        #1;
        check_output("areset_nxtpos", 32'(ROB_nxtpos), 32'd0);
        check_output("areset_full", 32'(ROB_full), 32'd0);
        check_output("areset_commit_s", 32'(Commit_S), 32'd0);
        check_output("areset_store_s", 32'(Store_commit_S), 32'd0);
        check_output("areset_flush_s", 32'(Flush_S), 32'd0);
        apply_stimulus();
        rst_in = 1;

        // Fill, overflow attempt, and wrap-around allocation.
        for (int i = 0; i < ROB_SIZE; i++) begin
            alloc(5'(i + 1), 1, 0); apply_stimulus();
        end
        check_output("fill_full", 32'(ROB_full), 32'd1);
        check_output("fill_nxtpos", 32'(ROB_nxtpos), 32'd0);
        alloc(19, 1, 0); apply_stimulus();
        check_output("over_nxtpos", 32'(ROB_nxtpos), 32'd0);
        alu_write(0, 32'h100, 0, 0); apply_stimulus();
        alloc(20, 1, 0); apply_stimulus();
        check_output("full_commit_value", Commit_value, 32'h100);
        check_output("full_commit_nxtpos", 32'(ROB_nxtpos), 32'd0);
        check_output("full_commit_full", 32'(ROB_full), 32'd0);
        alloc(21, 1, 0); apply_stimulus();
        check_output("wrap_nxtpos", 32'(ROB_nxtpos), 32'd1);
        check_output("wrap_full", 32'(ROB_full), 32'd1);

        // Mispredict flush with younger entries live.
        rst_in = 0; apply_stimulus(); rst_in = 1;
        for (int i = 0; i < 6; i++) begin
            alloc(5'(i + 1), 1, 0); apply_stimulus();
        end
        alu_write(0, 32'h70, 0, 0); apply_stimulus();
        alu_write(1, 32'h77, 1, 32'h1000); lsb_write(2, 32'h88); apply_stimulus();
        check_output("pre_flush_value", Commit_value, 32'h70);
        alloc(30, 1, 0); alu_write(3, 32'h99, 0, 0); apply_stimulus();
        check_output("flush_s", 32'(Flush_S), 32'd1);
        check_output("flush_pc", Flush_pc, 32'h1000);
        check_output("flush_commit_value", Commit_value, 32'h77);
        check_output("flush_nxtpos", 32'(ROB_nxtpos), 32'd0);
        alu_write(3, 32'hBEEF, 0, 0); apply_stimulus();
        check_output("flush_s_drop", 32'(Flush_S), 32'd0);
        ROB_rs1_S = 1; ROB_rs1_Reorder = 3; ROB_rs2_S = 1; ROB_rs2_Reorder = 2;
        #1;
        check_output("dropped_wb_tag3", 32'(ROB_rs1_already), 32'd0);
        check_output("flushed_tag2", 32'(ROB_rs2_already), 32'd0);
        apply_stimulus();
        ROB_rs1_S = 0; ROB_rs2_S = 0;
        alloc(9, 1, 0); apply_stimulus();
        check_output("post_flush_nxtpos", 32'(ROB_nxtpos), 32'd1);
        repeat (2) apply_stimulus();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order commit buffer; the far end of the dispatch interface.
- Allocates one entry per dispatched instruction and returns the entry index as its Reorder tag.
- Answers operand-forwarding queries for rs1/rs2 tags.
- Records CDB results from the ALU and LSB, then retires entries in program order: register writes, store release, mispredict flush.

Parameters:
ROB_SIZE, 16, number of entries (power of two)
ROB_W, 4, tag width = log2(ROB_SIZE)
DATA_W, 32, data/address width

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  asynchronous active-low reset
rdy_in  input  1  when low, all state holds; no commit, no allocation
ROB_S  input  1  dispatch allocate strobe
Dispatch_rd  input  5  destination register
Dispatch_rd_we  input  1  entry writes rd at commit
Dispatch_is_store  input  1  entry is a store
Dispatch_pc  input  DATA_W  instruction pc
ROB_nxtpos  output  ROB_W  tag the next allocation receives (= tail)
ROB_full  output  1  count == ROB_SIZE
ROB_rs1_S / ROB_rs2_S  input  1  query enables
ROB_rs1_Reorder / ROB_rs2_Reorder  input  ROB_W  queried tags
ROB_rs1_already / ROB_rs2_already  output  1  queried value available
ROB_rs1_value / ROB_rs2_value  output  DATA_W  queried value
ALU_S  input  1  ALU CDB valid
ALU_Reorder  input  ROB_W  ALU result tag
ALU_value  input  DATA_W  ALU result
ALU_mispred  input  1  control-flow result differs from prediction
ALU_newpc  input  DATA_W  correct next pc
LSB_S  input  1  LSB CDB valid (load data, or store address resolved)
LSB_Reorder  input  ROB_W  LSB tag
LSB_value  input  DATA_W  load data (ignored for stores)
Commit_S  output  1  register retire pulse
Commit_rd  output  5  retiring rd
Commit_value  output  DATA_W  retiring value
Commit_Reorder  output  ROB_W  retiring tag (regfile clears Q if it matches)
Store_commit_S  output  1  head store released to LSB
Store_commit_Reorder  output  ROB_W  released store tag
Flush_S  output  1  pipeline flush pulse
Flush_pc  output  DATA_W  redirect pc

Behaviour:
- Reset (rst_in low, async): head=tail=count=0, all valid/ready bits 0, every registered output 0. Combinational outputs follow from cleared state: ROB_nxtpos=0, ROB_full=0, already=0.
- Per entry: valid, ready, rd, rd_we, is_store, pc, value, mispred, newpc.
- Allocate, on a clock edge where ROB_S=1, rdy_in=1, ROB_full=0 and no flush is issued:
  - Write entry[tail] with valid=1, ready=0.
  - tail = tail+1 mod ROB_SIZE.
  - ROB_S while full is ignored; Dispatch must stall.
- Writeback, per edge:
  - ALU_S=1: entry[ALU_Reorder] gets ready=1, value, mispred, newpc.
  - LSB_S=1: entry[LSB_Reorder] gets ready=1, value, mispred=0.
  - Both ports may fire in the same cycle with distinct tags.
  - A writeback to an invalid entry is dropped.
- Query (combinational, per port):
  - already=1, value=ALU_value if ALU_S and tag matches;
  - else the LSB_S match;
  - else entry ready, value=entry.value;
  - else already=0, value=0.
  - Enable low gives already=0, value=0.
- Commit, per edge with rdy_in=1, count>0 and entry[head].ready:
  - Clear entry, head++ mod ROB_SIZE.
  - Registered outputs for the next cycle only:
    - rd_we → Commit_S=1 with rd/value/tag.
    - is_store → Store_commit_S=1 with tag.
    - mispred → Flush_S=1, Flush_pc=newpc.
  - One commit per cycle.
  - Latency: CDB write at edge t; commit at edge t+1; pulses visible in cycle after t+1.
  - All pulses return to 0 the following cycle unless another commit occurs.
- Flush, on the edge that commits a mispredicted entry:
  - Commit that entry (its rd write still pulses).
  - Simultaneously clear all valid bits and set head=tail=count=0.
  - Allocation and writeback on that same edge are discarded.
- count: +1 on allocate, −1 on commit, unchanged when both occur.
  - Commit of the head while full frees a slot only from the next cycle; ROB_full is registered-state based.
- Wrap-around: tail/head roll ROB_SIZE−1 → 0 seamlessly.

Test Plan:
- Reset mid-operation with 5 entries live: rst_in low → ROB_nxtpos=0, ROB_full=0, Commit_S=Store_commit_S=Flush_S=0 immediately, without waiting for a clock edge.
- Allocate tags 0,1,2 (rd 5,6,7); ALU writes tag2=0x33, tag0=0x11, tag1=0x22 in successive cycles → Commit_S pulses in tag order 0,1,2 with values 0x11,0x22,0x33.
- Query bypass: tag3 pending, ROB_rs1_Reorder=3 with ALU_S on tag3 value 0xABCD in the same cycle → ROB_rs1_already=1, ROB_rs1_value=0xABCD; the prior cycle gives already=0.
- Fill 16 entries → ROB_full=1; extra ROB_S is ignored, ROB_nxtpos unchanged; after one commit, allocation succeeds at tag 0 (wrap-around).
- Store tag4 gets LSB_S at head → Store_commit_S=1, Store_commit_Reorder=4, Commit_S=0.
- Branch tag1 ALU_mispred=1, ALU_newpc=0x1000, with tags 2–5 live → Flush_S=1, Flush_pc=0x1000; next cycle count=0, ROB_nxtpos=0, and a writeback to tag3 is dropped.
